// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every handshake and memory-bus signal of mem_port_arbiter.
//   Fetch port : IReq, IAddr -> IAck, IRData
//   Data port  : DReq, DWe, DAddr, DWData, DBe -> DAck, DRData
//   Memory     : MemEn, MemWe, MemBe, MemAddr, MemWData -> MemRData
//   Status     : Busy
// Modports:
//   slave  - the arbiter's view (requests and MemRData in, everything else out)
//   master - the environment's view (core ports plus memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic              IAck;
    logic [DATA_W-1:0] IRData;

    logic              DReq;
    logic              DWe;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic [BE_W-1:0]   DBe;
    logic              DAck;
    logic [DATA_W-1:0] DRData;

    logic              MemEn;
    logic              MemWe;
    logic [BE_W-1:0]   MemBe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;

    logic              Busy;

    modport slave (
        input  IReq, IAddr, DReq, DWe, DAddr, DWData, DBe, MemRData,
        output IAck, IRData, DAck, DRData,
               MemEn, MemWe, MemBe, MemAddr, MemWData, Busy
    );

    modport master (
        output IReq, IAddr, DReq, DWe, DAddr, DWData, DBe, MemRData,
        input  IAck, IRData, DAck, DRData,
               MemEn, MemWe, MemBe, MemAddr, MemWData, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch port (I) and
// the load/store port (D) of the core. One access is in flight at a time:
// IDLE -> ISSUE (MemEn) -> WAIT (MEM_LAT cycles) -> RESP (Ack) -> IDLE.
// D wins ties unless I has been passed over STARVE_MAX times in a row.
//
// Ports:
//   CLK, RST    clock and synchronous active-high reset
//   bus         mem_port_arbiter_if.slave (I/D request ports, memory bus, Busy)
//   IGrantCnt   (ARB_STATS_EN only) number of I grants, wraps mod 2^32
//   DGrantCnt   (ARB_STATS_EN only) number of D grants, wraps mod 2^32
//   ConflictCnt (ARB_STATS_EN only) IDLE cycles with IReq and DReq both high
//
// Optional feature: define ARB_STATS_EN to add the three statistics counters.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    mem_port_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]          IGrantCnt,
    output logic [31:0]          DGrantCnt,
    output logic [31:0]          ConflictCnt
`endif
);

    localparam int BE_W     = DATA_W / 8;
    localparam int CNT_W    = $clog2(MEM_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0]    WAIT_RELOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM  = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [STARVE_W-1:0] r_starve;
    logic                r_sel_d;      // current transaction belongs to D

    logic                r_mem_en;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                r_iack;
    logic                r_dack;
    logic [DATA_W-1:0]   r_irdata;
    logic [DATA_W-1:0]   r_drdata;
    logic                r_busy;

    logic                w_d_wins;
    logic                w_i_wins;
    logic [BE_W-1:0]     w_d_be;

    // Grant decision is only acted on in IDLE; starvation forces I once the
    // counter has saturated while I is still waiting.
    assign w_d_wins = bus.DReq & ~(bus.IReq & (r_starve >= STARVE_LIM));
    assign w_i_wins = bus.IReq & ~w_d_wins;

    // Loads access the full word; only stores honour DBe.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_d_be
        assign w_d_be[gi] = ~bus.DWe | bus.DBe[gi];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_starve    <= '0;
            r_sel_d     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_iack      <= 1'b0;
            r_dack      <= 1'b0;
            r_irdata    <= '0;
            r_drdata    <= '0;
            r_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are re-asserted only where needed.
            r_mem_en <= 1'b0;
            r_iack   <= 1'b0;
            r_dack   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!bus.IReq) begin
                        r_starve <= '0;
                    end
                    // Mem* registers are loaded here so they are already valid
                    // in the ISSUE cycle and hold until the next grant.
                    if (w_d_wins) begin
                        r_sel_d     <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= bus.DWe;
                        r_mem_be    <= w_d_be;
                        r_mem_addr  <= bus.DAddr;
                        r_mem_wdata <= bus.DWData;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                        if (bus.IReq && (r_starve < STARVE_LIM)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end else if (w_i_wins) begin
                        r_sel_d     <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '1;
                        r_mem_addr  <= bus.IAddr;
                        r_busy      <= 1'b1;
                        r_starve    <= '0;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_wait_cnt <= WAIT_RELOAD;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        // Last WAIT cycle: MemRData is valid now, so capture it
                        // and raise the Ack for the RESP cycle.
                        if (r_sel_d) begin
                            r_dack <= 1'b1;
                            if (!r_mem_we) begin
                                r_drdata <= bus.MemRData;
                            end
                        end else begin
                            r_iack   <= 1'b1;
                            r_irdata <= bus.MemRData;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end

                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.MemEn    = r_mem_en;
    assign bus.MemWe    = r_mem_we;
    assign bus.MemBe    = r_mem_be;
    assign bus.MemAddr  = r_mem_addr;
    assign bus.MemWData = r_mem_wdata;
    assign bus.IAck     = r_iack;
    assign bus.DAck     = r_dack;
    assign bus.IRData   = r_irdata;
    assign bus.DRData   = r_drdata;
    assign bus.Busy     = r_busy;

`ifdef ARB_STATS_EN
    logic [31:0] r_igrant_cnt;
    logic [31:0] r_dgrant_cnt;
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_igrant_cnt   <= '0;
            r_dgrant_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_d_wins) begin
                r_dgrant_cnt <= r_dgrant_cnt + 32'd1;
            end else if (w_i_wins) begin
                r_igrant_cnt <= r_igrant_cnt + 32'd1;
            end
            if (bus.IReq && bus.DReq) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign IGrantCnt   = r_igrant_cnt;
    assign DGrantCnt   = r_dgrant_cnt;
    assign ConflictCnt = r_conflict_cnt;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates a single-port unified memory between the instruction-fetch port (I) and the load/store port (D) of the MIPS_R2000 core.
- Serialises requests and issues one memory access at a time with fixed read latency.
- Returns read data and a one-cycle Ack to the winning port.
- D has priority; a starvation guard forces an I grant after repeated D wins.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- MEM_LAT, 2, cycles from the MemEn cycle to MemRData valid; minimum 1.
- STARVE_MAX, 4, consecutive D grants while IReq is pending before I is forced; minimum 1.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IReq  in  1  fetch request; held until IAck.
- IAddr  in  ADDR_W  fetch address; stable while IReq is high.
- IAck  out  1  one-cycle completion pulse.
- IRData  out  DATA_W  fetched word; valid in the IAck cycle, then held.
- DReq  in  1  load/store request; held until DAck.
- DWe  in  1  1 = store, 0 = load.
- DAddr  in  ADDR_W  data address.
- DWData  in  DATA_W  store data.
- DBe  in  DATA_W/8  store byte enables.
- DAck  out  1  one-cycle completion pulse.
- DRData  out  DATA_W  load data; valid in the DAck cycle, then held.
- MemEn  out  1  memory access strobe, one cycle per transaction.
- MemWe  out  1  memory write enable, qualified by MemEn.
- MemBe  out  DATA_W/8  byte enables; all ones for I and for loads.
- MemAddr  out  ADDR_W  access address.
- MemWData  out  DATA_W  write data.
- MemRData  in  DATA_W  read data, valid MEM_LAT cycles after MemEn.
- Busy  out  1  high in any state other than IDLE.

Behaviour:

Reset (RST sampled high):
- State goes to IDLE and the starvation counter to 0.
- All outputs go to 0, including IRData and DRData.
- Reset mid-transaction aborts it: no Ack is issued, and MemEn is 0 from the next cycle.

States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.

IDLE:
- If neither request is high, stay in IDLE.
- Winner selection:
  - D wins if DReq=1, unless IReq=1 and starve >= STARVE_MAX.
  - Otherwise I wins if IReq=1.
- On a grant, latch the winner's address, data, byte enables and we, then go to ISSUE.

Starvation counter:
- Increments when D wins while IReq=1, saturating at STARVE_MAX.
- Clears on any I grant, and whenever IReq=0 in IDLE.

ISSUE (1 cycle):
- MemEn=1; MemWe, MemAddr, MemBe and MemWData are driven from the latched values.
- Next state is WAIT.
- Mem* address/data outputs hold their values until the next ISSUE; MemEn=0 outside ISSUE.

WAIT (MEM_LAT cycles):
- The cycle counter reloads in ISSUE.
- MemRData is sampled at the end of the last WAIT cycle.
- Next state is RESP.

RESP (1 cycle):
- The winner's Ack=1.
- For reads, the winner's RData holds the sampled word.
- For stores, DRData is unchanged.
- The other port's Ack=0 and its RData is unchanged.
- Next state is IDLE.

Latency:
- Request seen in IDLE at cycle 0 -> MemEn at cycle 1 -> Ack at cycle MEM_LAT+2.
- Back-to-back throughput is one access per MEM_LAT+3 cycles.

Requester rules:
- A requester must drop Req on the edge following Ack.
- A Req still high in the following IDLE is a new request.
- A Req arriving during a transaction waits; it is never lost.

Simultaneous IReq and DReq in IDLE: D wins unless the starvation guard applies.

Busy=1 exactly in ISSUE, WAIT and RESP.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds output ports:
  - IGrantCnt, 32 bits: increments on each I grant.
  - DGrantCnt, 32 bits: increments on each D grant.
  - ConflictCnt, 32 bits: increments in IDLE whenever IReq=1 and DReq=1 together.
  - All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Single I read (MEM_LAT=2):
  - Stimulus: IReq=1, IAddr=0x00400000, memory returns 0x8FA40000.
  - Required: MemEn high in cycle 1 with MemAddr=0x00400000, MemBe=0xF, MemWe=0; IAck=1 in cycle 4; IRData=0x8FA40000; DAck stays 0.
- D store:
  - Stimulus: DReq=1, DWe=1, DAddr=0x10010004, DWData=0xDEADBEEF, DBe=0x3.
  - Required: ISSUE drives MemWe=1, MemBe=0x3; DAck in cycle 4; DRData unchanged.
- Simultaneous IReq and DReq:
  - Required: D is granted first with DAck at cycle 4; I is granted in the following IDLE with IAck at cycle 9; both Acks are single-cycle.
- Starvation (STARVE_MAX=4):
  - Stimulus: IReq held high, DReq re-asserted every IDLE.
  - Required: exactly 4 D grants, then an I grant; the counter clears and the pattern repeats.
- Reset mid-transaction:
  - Stimulus: RST=1 during WAIT.
  - Required: no Ack, Busy=0 and MemEn=0 the next cycle; a fresh IReq afterwards completes normally.
- With ARB_STATS_EN:
  - Stimulus: the simultaneous-request scenario above.
  - Required: IGrantCnt=1, DGrantCnt=1, ConflictCnt=1; all counters read 0 after RST.
